// File: rtl/dmem_dma_pkg.sv
// Shared types for the data-memory DMA copy engine.
// Holds the FSM state encoding and the word size in bytes.
package dma_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic misaligned(
    input logic [31:0] a
  );
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_dma_if.sv
// Data-memory bus between the DMA (master) and memory/IO (slave).
// Ports: bus_req/bus_a/bus_we/bus_wd out of the master, bus_gnt/bus_rd in.
interface dmem_dma_if;

  logic        bus_req;
  logic [31:0] bus_a;
  logic        bus_we;
  logic [31:0] bus_wd;
  logic        bus_gnt;
  logic [31:0] bus_rd;

  modport master (
    output bus_req,
    output bus_a,
    output bus_we,
    output bus_wd,
    input  bus_gnt,
    input  bus_rd
  );

  modport slave (
    input  bus_req,
    input  bus_a,
    input  bus_we,
    input  bus_wd,
    output bus_gnt,
    output bus_rd
  );

endinterface

// File: rtl/dmem_dma.sv
// Word-by-word DMA copy: reads src, writes dst, len words, ascending.
// Ports: clk, reset (sync, high), start/src/dst/len, bus (master), busy/done/err.
module dmem_dma
  import dma_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  dmem_dma_if.master       bus,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [LEN_W-1:0] cnt;
  logic [31:0]      data_reg;
  logic             err_q;

  logic             reject;
  logic             bad_align;

  assign bad_align = misaligned(src) | misaligned(dst);
  assign reject    = (len == '0) | bad_align;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      src_ptr  <= '0;
      dst_ptr  <= '0;
      cnt      <= '0;
      data_reg <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            src_ptr <= src;
            dst_ptr <= dst;
            cnt     <= len;
            err_q   <= bad_align;
            state   <= reject ? DONE : READ;
          end
        end
        READ: begin
          if (bus.bus_gnt) begin
            data_reg <= bus.bus_rd;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (bus.bus_gnt) begin
            src_ptr <= src_ptr + 32'(WORD_BYTES);
            dst_ptr <= dst_ptr + 32'(WORD_BYTES);
            cnt     <= cnt - LEN_W'(1);
            state   <= (cnt == LEN_W'(1)) ? DONE : READ;
          end
        end
        DONE: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.bus_req = 1'b0;
    bus.bus_a   = '0;
    bus.bus_we  = 1'b0;
    bus.bus_wd  = '0;
    unique case (state)
      READ: begin
        bus.bus_req = 1'b1;
        bus.bus_a   = src_ptr;
      end
      WRITE: begin
        bus.bus_req = 1'b1;
        bus.bus_a   = dst_ptr;
        bus.bus_wd  = data_reg;
        bus.bus_we  = bus.bus_gnt;
      end
      default: ;
    endcase
  end

  assign busy = state != IDLE;
  assign done = state == DONE;
  assign err  = done & err_q;

endmodule
